// File: rtl/centipede_pkg.sv
// Shared constants and types for the centipede ROM download path.
// Used by the ioctl loader and its reset stretcher.
package centipede_pkg;

    localparam int         ROM_BYTES_DEFAULT = 16384;
    localparam logic [7:0] DL_INDEX_ROM      = 8'd0;

    typedef enum logic {
        IDLE,
        STROBE
    } dl_state_t;

    // Byte counter stops at all-ones instead of wrapping.
    function automatic logic [16:0] sat_inc17(input logic [16:0] value);
        return (&value) ? value : value + 17'd1;
    endfunction

endpackage

// File: rtl/dl_reset_stretch.sv
// Loadable down-counter that keeps the core in reset while a load is running
// and for RST_EXTEND cycles after the load input drops.
module dl_reset_stretch #(
    parameter int RST_EXTEND = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy,
    output logic expiring
);

    logic [7:0] count;

    // Starting loaded means the core also sits in reset for RST_EXTEND
    // cycles after the system reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'(RST_EXTEND);
        end else if (load) begin
            count <= 8'(RST_EXTEND);
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign busy     = (count != 8'd0);
    assign expiring = !load && (count == 8'd1);

endmodule

// File: rtl/centipede_dl_loader.sv
// Adapter from the host ioctl byte stream to the centipede ROM-load port:
// index filter, bounds check, fixed-length write strobe and load status.
module centipede_dl_loader
    import centipede_pkg::*;
#(
    parameter logic [7:0] ROM_INDEX  = DL_INDEX_ROM,
    parameter int         ROM_BYTES  = ROM_BYTES_DEFAULT,
    parameter int         WR_HOLD    = 2,
    parameter int         RST_EXTEND = 16
) (
    input  logic        clk_12,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        overflow,
    output logic [16:0] byte_count
);

    // Handshake: ioctl_wr is a one-cycle valid with no retry; ioctl_wait high
    // means not-ready, and any byte offered while it is high is lost and flagged.

    dl_state_t  state;
    logic [2:0] hold_cnt;
    logic       active;
    logic       active_q;
    logic       active_rise;
    logic       in_range;
    logic       hold_reset;
    logic       stretch_busy;
    logic       stretch_expiring;

    assign active      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign active_rise = active && !active_q;
    assign in_range    = (ioctl_addr < 25'(ROM_BYTES));
    // A strobe that outlives the download window keeps the core in reset.
    assign hold_reset  = active || (state == STROBE);

    dl_reset_stretch #(
        .RST_EXTEND(RST_EXTEND)
    ) u_reset_stretch (
        .clk     (clk_12),
        .rst     (reset),
        .load    (hold_reset),
        .busy    (stretch_busy),
        .expiring(stretch_expiring)
    );

    assign core_reset = stretch_busy;

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= 3'd0;
            active_q   <= 1'b0;
            ioctl_wait <= 1'b0;
            dn_addr    <= 16'd0;
            dn_data    <= 8'd0;
            dn_wr      <= 1'b0;
            rom_ready  <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= 17'd0;
        end else begin
            active_q <= active;

            if (active_rise) begin
                byte_count <= 17'd0;
                overflow   <= 1'b0;
                rom_ready  <= 1'b0;
            end

            // Lands on the same edge that the stretcher releases core_reset.
            if (stretch_expiring && (byte_count != 17'd0) && !overflow) begin
                rom_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ioctl_wr && active) begin
                        if (in_range) begin
                            state      <= STROBE;
                            dn_addr    <= ioctl_addr[15:0];
                            dn_data    <= ioctl_dout;
                            dn_wr      <= 1'b1;
                            ioctl_wait <= 1'b1;
                            hold_cnt   <= 3'(WR_HOLD - 1);
                            byte_count <= active_rise ? 17'd1 : sat_inc17(byte_count);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                STROBE: begin
                    if (ioctl_wr) begin
                        overflow <= 1'b1;
                    end
                    if (hold_cnt == 3'd0) begin
                        state      <= IDLE;
                        dn_wr      <= 1'b0;
                        ioctl_wait <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/centipede_dl_loader.md
# centipede_dl_loader

Download adapter between the host ioctl stream (MiSTer HPS or Verilator harness) and the centipede core's `dn_addr`/`dn_data`/`dn_wr` ROM-load port. It filters the stream by index, bounds-checks addresses, and stretches each byte into a fixed-length core write strobe while back-pressuring the host with `ioctl_wait`. It also holds the core in reset for the whole load and briefly afterwards, and reports load status.

## Interface
- `ROM_INDEX`, default 8'd0: `ioctl_index` value accepted as the ROM image.
- `ROM_BYTES`, default 16384: bytes accepted; higher addresses are dropped.
- `WR_HOLD`, default 2: cycles `dn_wr` stays high per byte (1..7).
- `RST_EXTEND`, default 16: `core_reset` cycles held after the download ends (1..255).

Ports:
- `clk_12`  in  1  system clock; all logic is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_download`  in  1  host download window.
- `ioctl_wr`  in  1  one-cycle byte-valid strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_index`  in  8  image selector.
- `ioctl_wait`  out  1  registered back-pressure to the host.
- `dn_addr`  out  16  core write address.
- `dn_data`  out  8  core write data.
- `dn_wr`  out  1  core write strobe.
- `core_reset`  out  1  reset request to the core; OR it with `reset` at top level.
- `rom_ready`  out  1  a clean image has been loaded.
- `overflow`  out  1  sticky flag: an out-of-range or protocol-violating byte was seen.
- `byte_count`  out  17  number of bytes written to the core during the current or last load.

## Operation
- **Active download:** `active = ioctl_download && ioctl_index == ROM_INDEX`.
- **IDLE:**
  - `ioctl_wr && active && ioctl_addr < ROM_BYTES`: latch `ioctl_addr[15:0]` and `ioctl_dout`, then go to STROBE.
  - `ioctl_wr && active && ioctl_addr >= ROM_BYTES`: drop the byte, set `overflow`, stay in IDLE, do not assert wait.
  - `ioctl_wr` with `active` low: ignore.
- **STROBE:**
  - `dn_wr` is high for exactly `WR_HOLD` cycles; `dn_addr`/`dn_data` stay stable.
  - `byte_count` increments on the first STROBE cycle.
  - After `WR_HOLD` cycles go to IDLE.
- **Protocol violation:** `ioctl_wr` arriving while `ioctl_wait` is high drops the byte and sets `overflow`.
- **Download start** (rising edge of `active`): clear `byte_count`, `overflow` and `rom_ready`; assert `core_reset`.
- **Download end** (falling edge of `active`):
  - Finish any STROBE in progress.
  - Then hold `core_reset` for `RST_EXTEND` more cycles before releasing it.
  - Set `rom_ready` if `byte_count != 0 && !overflow`.
  - If `active` rises again during the extension, the extension counter reloads.
- **Reset values:** `ioctl_wait=0`, `dn_addr=0`, `dn_data=0`, `dn_wr=0`, `core_reset=1`, `rom_ready=0`, `overflow=0`, `byte_count=0`. The post-reset `core_reset` releases after `RST_EXTEND` cycles.
- **Reset mid-operation:** a STROBE in progress is aborted and no further `dn_wr` is issued.

## Timing
- A byte accepted at edge N gives `dn_wr` high on cycles N+1 .. N+`WR_HOLD`.
- `ioctl_wait` is high on cycles N+1 .. N+`WR_HOLD`.
- Sustained throughput is one byte per `WR_HOLD`+1 cycles.
- `core_reset` asserts one cycle after `active` rises.
- `core_reset` falls `RST_EXTEND` cycles after the last of (`active` falls, STROBE ends).
- `rom_ready` rises in the same cycle that `core_reset` falls.
- `byte_count` saturates at 2^17-1 and does not wrap.

## Structure
- Shared package `centipede_pkg`: `ROM_BYTES_DEFAULT`, `DL_INDEX_ROM`, and the state enum `dl_state_t` {IDLE, STROBE}.
- Sub-module `dl_reset_stretch`: the loadable down-counter behind `core_reset`. It has a load input, counts `RST_EXTEND`, and outputs busy while nonzero.
- Everything else is a single FSM plus data and status registers in one module.

## Test plan
- Reset, then write byte 0xA5 at address 0x0010 with index 0 → `dn_wr` high for 2 cycles with `dn_addr=0x0010`, `dn_data=0xA5`; `ioctl_wait` high for the same 2 cycles; `byte_count=1`.
- Stream bytes 0..16383 honouring wait, then drop `ioctl_download` → 16384 core writes with data matching, `byte_count=16384`, `core_reset` falls 16 cycles later, `rom_ready=1`, `overflow=0`.
- Write to address 16384 during an active load → no `dn_wr`, `overflow=1`; at the end `rom_ready` stays 0.
- Assert `ioctl_wr` during a wait cycle → that byte is absent from the core writes, `overflow=1`.
- Stream with `ioctl_index=1` → no `dn_wr` at all, `core_reset` stays low after the initial release, `byte_count=0`.
- Assert async `reset` mid-STROBE → `dn_wr` and `ioctl_wait` drop immediately, `core_reset=1`, all status cleared; `core_reset` releases 16 cycles after `reset` deasserts.
